// File: rtl/serial_full_adder.sv
// Serial (bit-per-cycle) full adder.
// Adds two WIDTH-bit operands plus a carry-in, LSB first, one full-adder
// step per clock. A result takes WIDTH RUN cycles and is flagged by a single
// done pulse in the DONE state; a new start may be accepted in IDLE or DONE.
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             s_bit,
  output logic             s_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Counter only has to reach WIDTH-1; WIDTH >= 2 keeps CNT_W >= 1.
  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t             state, next_state;
  logic [WIDTH-1:0]   a_sh, b_sh, s_acc;
  logic [CNT_W-1:0]   cnt;
  logic               carry, cout_r;
  logic               accept, last_step, sum, c_next;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // A start is honoured only while not busy; requests during RUN are dropped.
  assign accept    = start && (state != RUN);
  assign last_step = (state == RUN) && (cnt == LAST);
  assign sum       = fa_sum(a_sh[0], b_sh[0], carry);
  assign c_next    = fa_carry(a_sh[0], b_sh[0], carry);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: IDLE/DONE jump to RUN on start, RUN ends after WIDTH steps.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_step) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand shifters, carry flop, step counter and sum accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      s_acc  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
    end else if (accept) begin
      a_sh   <= A;
      b_sh   <= B;
      s_acc  <= '0;
      cnt    <= '0;
      carry  <= cin;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      // Sum bits enter at the MSB so the first (LSB) bit ends up in bit 0.
      s_acc  <= {sum, s_acc[WIDTH-1:1]};
      carry  <= c_next;
      cnt    <= cnt + CNT_W'(1);
      // cout is only updated with the final carry so it holds between results.
      if (last_step) cout_r <= c_next;
    end
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign s_valid = busy;
  assign s_bit   = busy & sum;
  assign S       = s_acc;
  assign cout    = cout_r;

endmodule

// File: tb/tb_serial_full_adder.sv
// Directed bench for serial_full_adder (WIDTH=8) with an expected-result queue.
module tb_serial_full_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, cin;
  logic [W-1:0] A, B;
  logic         busy, done, cout, s_bit, s_valid;
  logic [W-1:0] S;

  int errors = 0;
  int checks = 0;
  logic [W:0]   exp_q[$];
  logic [W-1:0] bit_sr = '0;

  serial_full_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .cin(cin),
    .busy(busy), .done(done), .S(S), .cout(cout), .s_bit(s_bit), .s_valid(s_valid)
  );

  always #5 clk = ~clk;

  // Serial output monitor: gathers s_bit LSB first, sampled mid-cycle.
  always @(negedge clk) begin
    if (s_valid) bit_sr <= {s_bit, bit_sr[W-1:1]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request, queue its expected result, let the next edge accept it,
  // then scramble the operand inputs to show they are no longer looked at.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] e;
    A = a; B = b; cin = c; start = 1'b1;
    e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    exp_q.push_back(e);
    step();
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); cin = 1'($urandom);
  endtask

  // Wait (bounded) for done, check latency, then pop and compare the result.
  task automatic wait_done(input string tag, input int exp_edges);
    int n = 0;
    logic [W:0] e;
    while (!done && n < 3 * W) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, exp_edges);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_sb_pending"}, exp_q.size() != 0, 1'b1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    chk({tag, "_S"}, S, e[W-1:0]);
    chk({tag, "_cout"}, cout, e[W]);
    chk({tag, "_sbits"}, bit_sr, e[W-1:0]);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; cin = 1'b0;
    #12;
    chk("reset_outputs", {busy, done, s_valid, s_bit, cout, S}, '0);
    step();
    rst_n = 1'b1;

    // Zero add
    launch(8'h00, 8'h00, 1'b0);
    chk("zero_busy", busy, 1'b1);
    chk("zero_svalid", s_valid, 1'b1);
    wait_done("zero", W);
    step();
    chk("zero_done_pulse", done, 1'b0);

    // Overflow, then result holds in IDLE
    launch(8'hFF, 8'h01, 1'b0);
    wait_done("ovf", W);
    step();
    chk("ovf_idle", {busy, done, s_valid}, 3'b000);
    step();
    chk("ovf_hold", {cout, S}, {1'b1, 8'h00});

    // Carry-in ripple
    launch(8'hA5, 8'h5A, 1'b1);
    wait_done("ripple", W);
    step();
    chk("ripple_done_pulse", done, 1'b0);

    // Start during RUN is ignored
    launch(8'h3C, 8'h0F, 1'b0);
    step();
    step();
    A = 8'hFF; B = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    wait_done("ignore", W - 3);
    step();
    chk("ignore_no_restart", {busy, done}, 2'b00);

    // Back-to-back: new start while done is high
    launch(8'h12, 8'h34, 1'b0);
    wait_done("b2b_first", W);
    launch(8'h80, 8'h80, 1'b0);
    chk("b2b_no_idle", busy, 1'b1);
    wait_done("b2b_second", W);

    // Reset mid-operation
    launch(8'h77, 8'h11, 1'b0);
    step(); step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {busy, done, s_valid, s_bit, cout, S}, '0);
    exp_q.delete();
    step();
    step();
    chk("midrst_no_done", {busy, done}, 2'b00);
    rst_n = 1'b1;
    launch(8'h01, 8'h01, 1'b0);
    chk("postrst_accept", busy, 1'b1);
    wait_done("postrst", W);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
